// File: rtl/mat_pair_reduce_pkg.sv
// ---------------------------------------------------------------------------
// mpr_pkg
// Shared definitions for the mat_pair_reduce matrix-pair engine:
//   - query mode codes (2-bit, as presented on the mode input)
//   - controller state encoding
//   - matrix_size code -> matrix dimension decode
// ---------------------------------------------------------------------------
package mpr_pkg;

    localparam logic [1:0] MODE_TR_AB  = 2'd0;  // trace(A*B)
    localparam logic [1:0] MODE_FROB   = 2'd1;  // Frobenius inner product
    localparam logic [1:0] MODE_SUM_AB = 2'd2;  // sum of all elements of A*B
    localparam logic [1:0] MODE_TR_TR  = 2'd3;  // tr(A) * tr(B)

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        QRY  = 3'd2,
        CALC = 3'd3,
        OUT  = 3'd4
    } state_t;

    // Size code s selects n = 2**(s+1): 0->2, 1->4, 2->8, 3->16.
    function automatic int unsigned size_to_n(input logic [1:0] code);
        return 32'd2 << code;
    endfunction

endpackage

// File: rtl/mat_pair_reduce_if.sv
// ---------------------------------------------------------------------------
// mat_pair_reduce_if
// Stimulus/result bundle of the matrix-pair engine.
//   in_valid    : load-phase element strobe
//   matrix      : element value, row-major, matrix 0 first
//   matrix_size : size code, meaningful on the first load element only
//   in_valid2   : query strobe (two cycles: idx A + mode, then idx B)
//   matrix_idx  : matrix selector for the query
//   mode        : query mode, meaningful on the first query cycle only
//   out_valid   : single-cycle result pulse
//   out_value   : signed result, zero whenever out_valid is low
// master = stimulus side, slave = engine side.
// ---------------------------------------------------------------------------
interface mat_pair_reduce_if #(
    parameter int DATA_W  = 8,
    parameter int NUM_MAT = 32,
    parameter int OUT_W   = 50
);
    localparam int IDX_W = $clog2(NUM_MAT);

    logic                    in_valid;
    logic [DATA_W-1:0]       matrix;
    logic [1:0]              matrix_size;
    logic                    in_valid2;
    logic [IDX_W-1:0]        matrix_idx;
    logic [1:0]              mode;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_value;

    modport master (
        output in_valid, matrix, matrix_size, in_valid2, matrix_idx, mode,
        input  out_valid, out_value
    );

    modport slave (
        input  in_valid, matrix, matrix_size, in_valid2, matrix_idx, mode,
        output out_valid, out_value
    );
endinterface

// File: rtl/mat_pair_reduce_mem.sv
// ---------------------------------------------------------------------------
// mpr_mem
// Matrix bank storage: NUM_MAT * MAX_DIM^2 elements of DATA_W bits.
// One write port, two independent registered read ports (operand A and B).
// Address layout is {matrix index, row, column}.
//   clk        : clock
//   i_we       : write enable
//   i_waddr    : write address
//   i_wdata    : write data
//   i_raddr_a  : read address, port A
//   i_raddr_b  : read address, port B
//   o_rdata_a  : read data, port A (one cycle after address)
//   o_rdata_b  : read data, port B (one cycle after address)
// Contents are deliberately not reset.
// ---------------------------------------------------------------------------
module mpr_mem #(
    parameter int DATA_W   = 8,
    parameter int NUM_MAT  = 32,
    parameter int DIM_LOG2 = 4,
    parameter int ADDR_W   = $clog2(NUM_MAT) + 2 * DIM_LOG2
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata_a <= r_mem[i_raddr_a];
        o_rdata_b <= r_mem[i_raddr_b];
    end
endmodule

// File: rtl/mat_pair_reduce.sv
// ---------------------------------------------------------------------------
// mat_pair_reduce
// Loads a bank of NUM_MAT signed n x n matrices and answers two-matrix
// queries with a single signed scalar (trace(A*B), <A,B>_F, sum(A*B) or
// tr(A)*tr(B)). Result appears n*n+3 cycles after idx B is sampled.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : stimulus/result bundle (slave side)
// Iteration order is k outer, i inner so that each inner sweep covers one
// column of A and the matching row of B (needed for the sum(A*B) mode).
// Pipeline: address issue -> registered read -> multiply -> accumulate ->
// output register.
// ---------------------------------------------------------------------------
module mat_pair_reduce
    import mpr_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_MAT  = 32,
    parameter int DIM_LOG2 = 4,
    parameter int OUT_W    = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    mat_pair_reduce_if.slave  bus
);
    localparam int IDX_W  = $clog2(NUM_MAT);
    localparam int ADDR_W = IDX_W + 2 * DIM_LOG2;
    localparam int SUM_W  = DATA_W + DIM_LOG2 + 1;   // holds n signed elements
    localparam int PROD_W = 2 * DATA_W;
    localparam int XW     = 2 * SUM_W;

    state_t                r_state;
    logic [1:0]            r_mode;
    logic [IDX_W-1:0]      r_idx_a, r_idx_b, r_ld_mat;
    logic [DIM_LOG2-1:0]   r_n_m1, r_ld_row, r_ld_col, r_i, r_k;

    // pipeline registers
    logic                      r_v1, r_diag1, r_sweep1, r_last1;
    logic                      r_v2, r_sweep2, r_last2;
    logic signed [PROD_W-1:0]  r_prod2;
    logic signed [DATA_W-1:0]  r_a2, r_b2;
    logic                      r_done3;
    logic signed [OUT_W-1:0]   r_acc;
    logic signed [SUM_W-1:0]   r_sum_a, r_sum_b;

    logic                      w_we, w_ld_last, w_i_end, w_k_end;
    logic [DIM_LOG2-1:0]       w_size_n_m1;
    logic [ADDR_W-1:0]         w_waddr, w_raddr_a, w_raddr_b;
    logic [DATA_W-1:0]         w_rd_a, w_rd_b;
    logic signed [DATA_W-1:0]  w_a, w_b;
    logic signed [SUM_W-1:0]   w_sum_a_nx, w_sum_b_nx;
    logic signed [XW-1:0]      w_cross, w_tr_prod;

    assign w_size_n_m1 = DIM_LOG2'(size_to_n(bus.matrix_size) - 32'd1);
    assign w_i_end     = (r_i == r_n_m1);
    assign w_k_end     = (r_k == r_n_m1);
    assign w_ld_last   = (r_ld_col == r_n_m1) && (r_ld_row == r_n_m1) &&
                         (r_ld_mat == IDX_W'(NUM_MAT - 1));

    // Element 0 is written from IDLE, so the write address there is zero.
    assign w_we      = bus.in_valid && (r_state == IDLE || r_state == LOAD);
    assign w_waddr   = (r_state == LOAD) ? {r_ld_mat, r_ld_row, r_ld_col} : '0;
    assign w_raddr_a = {r_idx_a, r_i, r_k};                        // A[i][k]
    assign w_raddr_b = (r_mode == MODE_FROB) ? {r_idx_b, r_i, r_k} // B[i][k]
                                             : {r_idx_b, r_k, r_i};// B[k][i]

    mpr_mem #(
        .DATA_W   (DATA_W),
        .NUM_MAT  (NUM_MAT),
        .DIM_LOG2 (DIM_LOG2),
        .ADDR_W   (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (bus.matrix),
        .i_raddr_a (w_raddr_a),
        .i_raddr_b (w_raddr_b),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mode   <= '0;
            r_idx_a  <= '0;
            r_idx_b  <= '0;
            r_n_m1   <= '0;
            r_ld_mat <= '0;
            r_ld_row <= '0;
            r_ld_col <= '0;
            r_i      <= '0;
            r_k      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_n_m1   <= w_size_n_m1;
                        r_ld_mat <= '0;
                        r_ld_row <= '0;
                        r_ld_col <= DIM_LOG2'(1);   // n >= 2, element 0 already written
                        r_state  <= LOAD;
                    end else if (bus.in_valid2) begin
                        r_idx_a <= bus.matrix_idx;
                        r_mode  <= bus.mode;
                        r_state <= QRY;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        if (w_ld_last) begin
                            r_ld_mat <= '0;
                            r_ld_row <= '0;
                            r_ld_col <= '0;
                            r_state  <= IDLE;
                        end else if (r_ld_col == r_n_m1) begin
                            r_ld_col <= '0;
                            if (r_ld_row == r_n_m1) begin
                                r_ld_row <= '0;
                                r_ld_mat <= r_ld_mat + IDX_W'(1);
                            end else begin
                                r_ld_row <= r_ld_row + DIM_LOG2'(1);
                            end
                        end else begin
                            r_ld_col <= r_ld_col + DIM_LOG2'(1);
                        end
                    end
                end
                QRY: begin
                    r_idx_b <= bus.matrix_idx;
                    r_i     <= '0;
                    r_k     <= '0;
                    r_state <= CALC;
                end
                CALC: begin
                    if (w_i_end) begin
                        r_i <= '0;
                        if (w_k_end) begin
                            r_k     <= '0;
                            r_state <= OUT;
                        end else begin
                            r_k <= r_k + DIM_LOG2'(1);
                        end
                    end else begin
                        r_i <= r_i + DIM_LOG2'(1);
                    end
                end
                OUT: begin
                    // wait for the pipeline to drain; leaves with the result pulse
                    if (r_done3) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ---------------- datapath ----------------
    assign w_a        = $signed(w_rd_a);
    assign w_b        = $signed(w_rd_b);
    assign w_sum_a_nx = r_sum_a + SUM_W'(r_a2);
    assign w_sum_b_nx = r_sum_b + SUM_W'(r_b2);
    assign w_cross    = XW'(w_sum_a_nx) * XW'(w_sum_b_nx);
    assign w_tr_prod  = XW'(r_sum_a) * XW'(r_sum_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_diag1  <= 1'b0;
            r_sweep1 <= 1'b0;
            r_last1  <= 1'b0;
            r_v2     <= 1'b0;
            r_sweep2 <= 1'b0;
            r_last2  <= 1'b0;
            r_prod2  <= '0;
            r_a2     <= '0;
            r_b2     <= '0;
            r_done3  <= 1'b0;
            r_acc    <= '0;
            r_sum_a  <= '0;
            r_sum_b  <= '0;
        end else begin
            // stage 1: read data arrives; carry the iteration tags alongside
            r_v1     <= (r_state == CALC);
            r_diag1  <= (r_i == r_k);
            r_sweep1 <= w_i_end;
            r_last1  <= w_i_end && w_k_end;

            // stage 2: multiply; tr*tr mode keeps only diagonal operands
            r_v2     <= r_v1;
            r_sweep2 <= r_sweep1;
            r_last2  <= r_last1;
            r_prod2  <= PROD_W'(w_a) * PROD_W'(w_b);
            if (r_mode == MODE_TR_TR && !r_diag1) begin
                r_a2 <= '0;
                r_b2 <= '0;
            end else begin
                r_a2 <= w_a;
                r_b2 <= w_b;
            end

            // stage 3: accumulate
            r_done3 <= r_v2 && r_last2;
            if (r_state == QRY) begin
                r_acc   <= '0;
                r_sum_a <= '0;
                r_sum_b <= '0;
            end else if (r_v2) begin
                case (r_mode)
                    MODE_SUM_AB: begin
                        // column sum of A and row sum of B close at sweep end
                        if (r_sweep2) begin
                            r_acc   <= r_acc + OUT_W'(w_cross);
                            r_sum_a <= '0;
                            r_sum_b <= '0;
                        end else begin
                            r_sum_a <= w_sum_a_nx;
                            r_sum_b <= w_sum_b_nx;
                        end
                    end
                    MODE_TR_TR: begin
                        r_sum_a <= w_sum_a_nx;
                        r_sum_b <= w_sum_b_nx;
                    end
                    default: r_acc <= r_acc + OUT_W'(r_prod2);
                endcase
            end
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_value <= '0;
        end else if (r_done3) begin
            bus.out_valid <= 1'b1;
            bus.out_value <= (r_mode == MODE_TR_TR) ? OUT_W'(w_tr_prod) : r_acc;
        end else begin
            bus.out_valid <= 1'b0;
            bus.out_value <= '0;
        end
    end
endmodule

// File: tb/tb_mat_pair_reduce.sv
// ---------------------------------------------------------------------------
// tb_mat_pair_reduce
// Scoreboard bench: query tasks push the expected scalar and its arrival
// cycle; an independent negedge monitor pops on every out_valid pulse and
// otherwise requires out_value to be zero. Expected values come from the
// directed constants or from a matrix-algebra reference model.
// ---------------------------------------------------------------------------
module tb_mat_pair_reduce;
    import mpr_pkg::*;

    localparam int DATA_W   = 8;
    localparam int NUM_MAT  = 32;
    localparam int DIM_LOG2 = 4;
    localparam int OUT_W    = 50;
    localparam int MAX_DIM  = 16;
    localparam int IDX_W    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mat_pair_reduce_if #(.DATA_W(DATA_W), .NUM_MAT(NUM_MAT), .OUT_W(OUT_W)) bus ();

    mat_pair_reduce #(
        .DATA_W   (DATA_W),
        .NUM_MAT  (NUM_MAT),
        .DIM_LOG2 (DIM_LOG2),
        .OUT_W    (OUT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        longint val;
        int     cyc;
        int     tag;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   cur_n   = 2;
    int   tag_cnt = 0;
    int   mm [NUM_MAT][MAX_DIM][MAX_DIM];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        longint got;
        exp_t   e;
        got = longint'(bus.out_value);
        if (bus.out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_pulse cycle %0d got value %0d required no out_valid", cyc, got);
            end else begin
                e = sb.pop_front();
                if (got != e.val) begin
                    errors++;
                    $display("FAIL result tag %0d got %0d required %0d", e.tag, got, e.val);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL latency tag %0d got cycle %0d required cycle %0d", e.tag, cyc, e.cyc);
                end
                $display("txn %0d: value %0d (exp %0d) cycle %0d (exp %0d)", e.tag, got, e.val, cyc, e.cyc);
            end
        end else begin
            checks++;
            if (got != 0) begin
                errors++;
                $display("FAIL idle_value cycle %0d got %0d required 0", cyc, got);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog cycle %0d got no completion required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic longint ref_model(input int ia, input int ib, input int md);
        longint acc = 0;
        longint ta  = 0;
        longint tb  = 0;
        longint s;
        for (int i = 0; i < cur_n; i++) begin
            ta += longint'(mm[ia][i][i]);
            tb += longint'(mm[ib][i][i]);
            for (int j = 0; j < cur_n; j++) begin
                s = 0;
                for (int k = 0; k < cur_n; k++)
                    s += longint'(mm[ia][i][k]) * longint'(mm[ib][k][j]);   // (A*B)[i][j]
                if (md == 0 && i == j) acc += s;
                if (md == 1) acc += longint'(mm[ia][i][j]) * longint'(mm[ib][i][j]);
                if (md == 2) acc += s;
            end
        end
        if (md == 3) acc = ta * tb;
        return acc;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        bus.in_valid    = 1'b0;
        bus.in_valid2   = 1'b0;
        bus.matrix      = DATA_W'($urandom);
        bus.matrix_size = 2'($urandom);
        bus.matrix_idx  = IDX_W'($urandom);
        bus.mode        = 2'($urandom);
    endtask

    task automatic fill_random();
        for (int m = 0; m < NUM_MAT; m++)
            for (int r = 0; r < MAX_DIM; r++)
                for (int c = 0; c < MAX_DIM; c++)
                    mm[m][r][c] = int'($urandom_range(0, 255)) - 128;
    endtask

    // Streams the n x n region of every model matrix, with random gaps and
    // stray in_valid2 pulses (both must be ignored by the DUT).
    task automatic load_bank(input int size_code);
        bit first = 1'b1;
        cur_n = 2 << size_code;
        for (int m = 0; m < NUM_MAT; m++)
            for (int r = 0; r < cur_n; r++)
                for (int c = 0; c < cur_n; c++) begin
                    if (!first && $urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                        drive_idle();
                        bus.in_valid2 = 1'($urandom);
                    end
                    @(posedge clk); #1;
                    drive_idle();
                    bus.in_valid = 1'b1;
                    bus.matrix   = DATA_W'(mm[m][r][c]);
                    if (first) bus.matrix_size = 2'(size_code);
                    else       bus.in_valid2   = 1'($urandom);
                    first = 1'b0;
                end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout cycle %0d got %0d pending required 0", cyc, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_query(input int ia, input int ib, input int md, input longint expv,
                            input bit poke, input bit expect_out);
        exp_t e;
        @(posedge clk); #1;
        drive_idle();
        bus.in_valid2  = 1'b1;
        bus.matrix_idx = IDX_W'(ia);
        bus.mode       = 2'(md);
        @(posedge clk); #1;
        bus.matrix_idx = IDX_W'(ib);
        bus.mode       = 2'($urandom);
        @(posedge clk); #1;              // idx B was sampled at this edge
        drive_idle();
        if (expect_out) begin
            tag_cnt++;
            e.val = expv;
            e.cyc = cyc + cur_n * cur_n + 3;
            e.tag = tag_cnt;
            sb.push_back(e);
        end
        if (poke) begin                  // stray strobes during CALC
            @(posedge clk); #1;
            bus.in_valid2 = 1'b1;
            bus.in_valid  = 1'b1;
            @(posedge clk); #1;
            drive_idle();
        end
        if (expect_out) wait_drain(cur_n * cur_n + 20);
    endtask

    task automatic load_lab_pair();
        for (int m = 0; m < NUM_MAT; m++)
            for (int r = 0; r < MAX_DIM; r++)
                for (int c = 0; c < MAX_DIM; c++)
                    mm[m][r][c] = 0;
        mm[0][0][0] = 1; mm[0][0][1] = 2; mm[0][1][0] = 3; mm[0][1][1] = 4;
        mm[1][0][0] = 5; mm[1][0][1] = 6; mm[1][1][0] = 7; mm[1][1][1] = 8;
        load_bank(0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ia, ib, md;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %0b required 0", bus.out_valid);
        end
        checks++;
        if (bus.out_value !== '0) begin
            errors++;
            $display("FAIL reset_value got %0d required 0", bus.out_value);
        end
        rst_n = 1'b1;

        // 2x2 lab pair, all four modes
        load_lab_pair();
        do_query(0, 1, MODE_TR_AB,  69,  1'b0, 1'b1);
        do_query(0, 1, MODE_FROB,   70,  1'b1, 1'b1);
        do_query(0, 1, MODE_SUM_AB, 134, 1'b0, 1'b1);
        do_query(0, 1, MODE_TR_TR,  65,  1'b0, 1'b1);

        // 16x16 extreme negative values, stray strobes during load and calc
        fill_random();
        for (int r = 0; r < MAX_DIM; r++)
            for (int c = 0; c < MAX_DIM; c++)
                mm[0][r][c] = -128;
        load_bank(3);
        do_query(0, 0, MODE_SUM_AB, 67108864, 1'b1, 1'b1);
        do_query(0, 0, MODE_TR_AB,  4194304,  1'b0, 1'b1);

        // reload with a smaller n; identity-scaled pair in the top slots
        fill_random();
        for (int r = 0; r < MAX_DIM; r++)
            for (int c = 0; c < MAX_DIM; c++) begin
                mm[31][r][c] = (r == c) ? 1 : 0;
                mm[30][r][c] = (r == c) ? 2 : 0;
            end
        load_bank(1);
        do_query(31, 30, MODE_TR_AB, 8, 1'b0, 1'b1);
        for (int q = 0; q < 8; q++) begin
            ia = int'($urandom_range(0, NUM_MAT - 1));
            ib = int'($urandom_range(0, NUM_MAT - 1));
            md = int'($urandom_range(0, 3));
            do_query(ia, ib, md, ref_model(ia, ib, md), 1'($urandom), 1'b1);
        end

        // reset in the middle of a calculation: abort, no result pulse
        do_query(0, 1, MODE_TR_AB, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_valid got %0b required 0", bus.out_valid);
        end
        checks++;
        if (bus.out_value !== '0) begin
            errors++;
            $display("FAIL abort_value got %0d required 0", bus.out_value);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (24) @(posedge clk);   // the monitor flags any leftover pulse

        load_lab_pair();
        do_query(0, 1, MODE_TR_AB, 69, 1'b0, 1'b1);

        // random bank at a random size, model-checked
        fill_random();
        load_bank(int'($urandom_range(0, 2)));
        for (int q = 0; q < 10; q++) begin
            ia = int'($urandom_range(0, NUM_MAT - 1));
            ib = int'($urandom_range(0, NUM_MAT - 1));
            md = int'($urandom_range(0, 3));
            do_query(ia, ib, md, ref_model(ia, ib, md), 1'($urandom), 1'b1);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
